// File: rtl/ysyx_23060236_icache_if.sv
// ysyx_23060236_icache_if: fetch request/response and refill read-burst signals of the icache
// master drives requests and memory beats; slave is the cache itself
interface ysyx_23060236_icache_if;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_inst;
    logic        resp_err;
    logic        resp_ready;
    logic        fence_i;
    logic [31:0] mem_araddr;
    logic        mem_arvalid;
    logic        mem_arready;
    logic [1:0]  mem_arburst;
    logic [3:0]  mem_arlen;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_rresp;
    logic        mem_rlast;
    logic        mem_rvalid;
    logic        mem_rready;
    modport master (
        output req_valid, req_addr, resp_ready, fence_i, mem_arready, mem_rdata, mem_rresp, mem_rlast, mem_rvalid,
        input  req_ready, resp_valid, resp_inst, resp_err, mem_araddr, mem_arvalid, mem_arburst, mem_arlen, mem_rready
    );
    modport slave (
        input  req_valid, req_addr, resp_ready, fence_i, mem_arready, mem_rdata, mem_rresp, mem_rlast, mem_rvalid,
        output req_ready, resp_valid, resp_inst, resp_err, mem_araddr, mem_arvalid, mem_arburst, mem_arlen, mem_rready
    );
endinterface

// File: rtl/ysyx_23060236_icache.sv
// ysyx_23060236_icache: direct-mapped read-only instruction cache with INCR burst line refill
// fence_i invalidates every line, deferred to the next IDLE cycle when the cache is busy
module ysyx_23060236_icache #(
    parameter int OFFSET_WIDTH = 4,
    parameter int INDEX_WIDTH  = 4
) (
    input logic clock,
    input logic reset,
    ysyx_23060236_icache_if.slave bus
);
    localparam int WORDS     = 2 ** (OFFSET_WIDTH - 2);
    localparam int LINES     = 2 ** INDEX_WIDTH;
    localparam int TAG_WIDTH = 32 - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int CW        = OFFSET_WIDTH - 2;
    typedef enum logic [2:0] {IDLE, LOOKUP, AR, R, RESP} state_t;
    state_t               state;
    logic [31:0]          addr;
    logic [LINES-1:0]     valid;
    logic [TAG_WIDTH-1:0] tags [LINES];
    logic [31:0]          data [LINES*WORDS];
    logic [CW-1:0]        cnt;
    logic                 err;
    logic                 fence_pend;
    logic [31:0]          inst;
    logic                 r_err;
    logic [INDEX_WIDTH-1:0] idx;
    logic [TAG_WIDTH-1:0] tag;
    logic [CW-1:0]        woff;
    logic                 hit;
    logic                 beat_err;
    logic                 unused_lo;
    assign idx       = addr[OFFSET_WIDTH +: INDEX_WIDTH];
    assign tag       = addr[31 -: TAG_WIDTH];
    assign woff      = addr[OFFSET_WIDTH-1:2];
    assign hit       = valid[idx] && tags[idx] == tag;
    assign beat_err  = err | (bus.mem_rresp != 2'b00);
    assign unused_lo = ^addr[1:0];
    assign bus.req_ready   = state == IDLE && !fence_pend;
    assign bus.resp_valid  = state == RESP;
    assign bus.resp_inst   = inst;
    assign bus.resp_err    = r_err;
    assign bus.mem_araddr  = {addr[31:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
    assign bus.mem_arvalid = state == AR;
    assign bus.mem_arburst = 2'b01;
    assign bus.mem_arlen   = 4'(WORDS - 1);
    assign bus.mem_rready  = state == R;
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            valid      <= '0;
            fence_pend <= 1'b0;
            cnt        <= '0;
            err        <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (bus.fence_i && state != IDLE) fence_pend <= 1'b1;
            case (state)
                IDLE: if (fence_pend) begin
                    valid      <= '0;
                    fence_pend <= 1'b0;
                end else if (bus.req_valid) begin
                    addr       <= bus.req_addr;
                    fence_pend <= bus.fence_i;
                    state      <= LOOKUP;
                end else if (bus.fence_i) valid <= '0;
                LOOKUP: if (hit) begin
                    inst  <= data[{idx, woff}];
                    r_err <= 1'b0;
                    state <= RESP;
                end else state <= AR;
                AR: if (bus.mem_arready) begin
                    cnt   <= '0;
                    err   <= 1'b0;
                    state <= R;
                end
                R: if (bus.mem_rvalid) begin
                    cnt <= cnt + 1'b1;
                    err <= beat_err;
                    if (cnt == woff) inst <= bus.mem_rdata;
                    // a line refilled with any error beat stays invalid so the next access retries
                    if (bus.mem_rlast) begin
                        valid[idx] <= ~beat_err;
                        r_err      <= beat_err;
                        state      <= RESP;
                    end
                end
                RESP: if (bus.resp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    always_ff @(posedge clock) begin
        if (!reset && state == R && bus.mem_rvalid) begin
            data[{idx, cnt}] <= bus.mem_rdata;
            if (bus.mem_rlast) tags[idx] <= tag;
        end
    end
endmodule

// File: tb/tb_ysyx_23060236_icache.sv
// tb_ysyx_23060236_icache: directed and randomized fetches checked against a line-level cache model
// the bench also plays the burst memory, with random beat gaps, AR stalls and error beats
module tb_ysyx_23060236_icache;
    localparam int OW    = 4;
    localparam int IW    = 4;
    localparam int WORDS = 2 ** (OW - 2);
    logic clock = 1'b0;
    logic reset = 1'b1;
    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] model [int];
    logic [31:0] ovr [logic [31:0]];
    ysyx_23060236_icache_if bus ();
    ysyx_23060236_icache #(.OFFSET_WIDTH(OW), .INDEX_WIDTH(IW)) dut (.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return ovr.exists(a) ? ovr[a] : (a * 32'h9e3779b1) ^ 32'h13572468;
    endfunction
    task automatic fetch(input logic [31:0] a, input int err_beat, input bit fence_mid, input int ar_stall, input int rr_stall);
        logic [31:0] line, araddr0, inst0;
        int idx, t, t_last, beat, stall, ar_cycles;
        bit exp_hit, seen_ar, exp_err, fenced;
        line = {a[31:OW], {OW{1'b0}}};
        idx = int'(a[OW +: IW]);
        exp_hit = model.exists(idx) && model[idx] == line;
        exp_err = 0; seen_ar = 0; fenced = 0;
        beat = 0; t_last = 0; ar_cycles = 0; stall = ar_stall; araddr0 = '0;
        bus.req_valid = 1'b1; bus.req_addr = a; bus.resp_ready = 1'b0;
        t = 0;
        while (!bus.req_ready && t < 20) begin
            @(negedge clock);
            t++;
        end
        check("accept", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clock);
        bus.req_valid = 1'b0;
        t = 1;
        while (!bus.resp_valid && t < 200) begin
            bus.mem_arready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rlast = 1'b0; bus.mem_rresp = 2'b00; bus.fence_i = 1'b0;
            if (bus.mem_arvalid) begin
                if (!seen_ar) begin
                    seen_ar = 1; araddr0 = bus.mem_araddr;
                    check("araddr", bus.mem_araddr, line);
                    check("arlen", 32'(bus.mem_arlen), WORDS - 1);
                    check("arburst", 32'(bus.mem_arburst), 32'd1);
                end else check("araddr_hold", bus.mem_araddr, araddr0);
                ar_cycles++;
                if (stall == 0) bus.mem_arready = 1'b1; else stall--;
            end
            if (bus.mem_rready && beat < WORDS) begin
                if (fence_mid && !fenced) begin
                    bus.fence_i = 1'b1;
                    fenced = 1;
                end
                if ($urandom_range(0, 3) != 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata = mem_val(line + 32'(4 * beat));
                    bus.mem_rresp = beat == err_beat ? 2'b10 : 2'b00;
                    if (beat == err_beat) exp_err = 1;
                    bus.mem_rlast = beat == WORDS - 1;
                    if (beat == WORDS - 1) t_last = t;
                    beat++;
                end
            end
            @(negedge clock);
            t++;
        end
        bus.mem_arready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rlast = 1'b0; bus.mem_rresp = 2'b00; bus.fence_i = 1'b0;
        check("resp_valid", {31'd0, bus.resp_valid}, 32'd1);
        check("miss", {31'd0, seen_ar}, {31'd0, !exp_hit});
        if (exp_hit) check("hit_latency", t, 2);
        else begin
            check("miss_latency", t, t_last + 1);
            check("ar_cycles", ar_cycles, ar_stall + 1);
        end
        check("inst", bus.resp_inst, mem_val({a[31:2], 2'b00}));
        check("err", {31'd0, bus.resp_err}, {31'd0, exp_err});
        inst0 = bus.resp_inst;
        for (int i = 0; i < rr_stall; i++) begin
            @(negedge clock);
            check("resp_hold_valid", {31'd0, bus.resp_valid}, 32'd1);
            check("resp_hold_inst", bus.resp_inst, inst0);
        end
        bus.resp_ready = 1'b1;
        @(negedge clock);
        bus.resp_ready = 1'b0;
        if (fenced) model.delete();
        else if (!exp_hit) begin
            if (exp_err) model.delete(idx); else model[idx] = line;
        end
    endtask
    task automatic fence_idle();
        bus.fence_i = 1'b1;
        @(negedge clock);
        bus.fence_i = 1'b0;
        model.delete();
    endtask
    task automatic reset_mid_burst(input logic [31:0] a);
        int n, beats;
        n = 0; beats = 0;
        bus.req_valid = 1'b1; bus.req_addr = a;
        while (!bus.req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        bus.req_valid = 1'b0;
        while (beats < 2 && n < 60) begin
            bus.mem_arready = bus.mem_arvalid;
            bus.mem_rvalid = bus.mem_rready;
            bus.mem_rdata = 32'hdead0000 + 32'(beats);
            bus.mem_rlast = 1'b0;
            if (bus.mem_rready) beats++;
            @(negedge clock);
            n++;
        end
        bus.mem_arready = 1'b0; bus.mem_rvalid = 1'b0;
        check("rready_before_reset", {31'd0, bus.mem_rready}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check("rready_after_reset", {31'd0, bus.mem_rready}, 32'd0);
        check("resp_valid_after_reset", {31'd0, bus.resp_valid}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("req_ready_after_reset", {31'd0, bus.req_ready}, 32'd1);
        check("arvalid_after_reset", {31'd0, bus.mem_arvalid}, 32'd0);
        model.delete();
    endtask
    initial begin
        logic [31:0] a;
        int eb;
        bit fm;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.resp_ready = 1'b0; bus.fence_i = 1'b0;
        bus.mem_arready = 1'b0; bus.mem_rdata = '0; bus.mem_rresp = 2'b00; bus.mem_rlast = 1'b0; bus.mem_rvalid = 1'b0;
        ovr[32'h30000000] = 32'h11;
        ovr[32'h30000004] = 32'h22;
        ovr[32'h30000008] = 32'h33;
        ovr[32'h3000000c] = 32'h44;
        repeat (3) @(negedge clock);
        check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_arvalid", {31'd0, bus.mem_arvalid}, 32'd0);
        check("rst_rready", {31'd0, bus.mem_rready}, 32'd0);
        check("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("post_rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        fetch(32'h30000000, -1, 0, 0, 0);
        fetch(32'h30000008, -1, 0, 0, 0);
        fetch(32'h30000010, -1, 0, 5, 3);
        fetch(32'h30000100, -1, 0, 0, 0);
        fetch(32'h30000000, -1, 0, 0, 0);
        fetch(32'h30000004, -1, 0, 0, 2);
        fetch(32'h30000020, 2, 0, 0, 0);
        fetch(32'h30000024, -1, 0, 0, 0);
        fetch(32'h30000034, -1, 0, 0, 0);
        fetch(32'h30000040, -1, 1, 0, 0);
        fetch(32'h30000040, -1, 0, 0, 0);
        fetch(32'h30000030, -1, 0, 0, 0);
        fetch(32'h30000050, -1, 0, 0, 0);
        fetch(32'h30000054, -1, 0, 0, 0);
        fence_idle();
        fetch(32'h30000050, -1, 0, 0, 0);
        fetch(32'h30000060, -1, 0, 0, 0);
        reset_mid_burst(32'h30000070);
        fetch(32'h30000060, -1, 0, 0, 0);
        repeat (80) begin
            a = 32'h30000000 + 32'h100 * $urandom_range(0, 1) + 32'd4 * $urandom_range(0, 63);
            eb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, WORDS - 1)) : -1;
            fm = $urandom_range(0, 15) == 0;
            fetch(a, eb, fm, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
            if ($urandom_range(0, 19) == 0) fence_idle();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
